// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer: datapath opcodes, register-file
// indices and the sequencer state encoding.
package fir_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_COPY  = 3'd1;
    localparam logic [2:0] OP_LOAD1 = 3'd2;
    localparam logic [2:0] OP_LOAD2 = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    // R0 output, R1-R4 delay line (R1 newest), R5-R8 coefficients, R9 product, R10 accumulator
    localparam logic [3:0] R0  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_LDCOEF, S_WAITC, S_SH3, S_SH2, S_SH1, S_STORE, S_MUL0,
        S_MUL1, S_ADD1, S_MUL2, S_ADD2, S_MUL3, S_ADD3, S_OUT, S_EIDLE
    } state_t;

    function automatic logic [3:0] coef_reg(input logic [1:0] k);
        return R5 + {2'b00, k};
    endfunction

endpackage

// File: rtl/fir_sequencer.sv
// Control sequencer for a 4-tap FIR on a shared register-file datapath: loads
// coefficients, shifts the delay line and issues the multiply-accumulate steps.
module fir_sequencer
    import fir_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    input  logic       dr,
    input  logic       lc,
    input  logic       overflow,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       modwait,
    output logic       cnt_up,
    output logic       err
);

    state_t     state, state_d;
    logic [1:0] k, k_d;
    logic       load_ok_d;

    logic [2:0] op_d;
    logic [3:0] src1_d, src2_d, dest_d;
    logic       modwait_d, cnt_up_d, err_d;

    always_comb begin : next_state
        state_d   = state;
        k_d       = k;
        load_ok_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (lc)      state_d = S_LDCOEF;
                else if (dr) state_d = S_SH3;
            end
            S_LDCOEF: begin
                state_d = S_WAITC;
                k_d     = k + 2'd1;
            end
            S_WAITC: begin
                if (k == 2'd0) state_d = S_IDLE;
                else if (lc)   state_d = S_LDCOEF;
            end
            S_SH3: state_d = S_SH2;
            S_SH2: state_d = S_SH1;
            // Outputs are registered, so the store decision is taken while entering STORE
            S_SH1: begin
                state_d   = S_STORE;
                load_ok_d = dr;
            end
            S_STORE: state_d = cnt_up ? S_MUL0 : S_EIDLE;
            S_MUL0:  state_d = S_MUL1;
            S_MUL1:  state_d = S_ADD1;
            S_ADD1:  state_d = overflow ? S_EIDLE : S_MUL2;
            S_MUL2:  state_d = S_ADD2;
            S_ADD2:  state_d = overflow ? S_EIDLE : S_MUL3;
            S_MUL3:  state_d = S_ADD3;
            S_ADD3:  state_d = overflow ? S_EIDLE : S_OUT;
            S_OUT:   state_d = S_IDLE;
            S_EIDLE: begin
                if (lc) begin
                    state_d = S_LDCOEF;
                    k_d     = 2'd0;
                end else if (dr) begin
                    state_d = S_SH3;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : out_decode
        op_d      = OP_NOP;
        src1_d    = R0;
        src2_d    = R0;
        dest_d    = R0;
        modwait_d = 1'b1;
        cnt_up_d  = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            S_LDCOEF: begin op_d = OP_LOAD2; dest_d = coef_reg(k_d); end
            S_SH3:    begin op_d = OP_COPY; src1_d = R3; dest_d = R4; end
            S_SH2:    begin op_d = OP_COPY; src1_d = R2; dest_d = R3; end
            S_SH1:    begin op_d = OP_COPY; src1_d = R1; dest_d = R2; end
            S_STORE: begin
                if (load_ok_d) begin
                    op_d     = OP_LOAD1;
                    dest_d   = R1;
                    cnt_up_d = 1'b1;
                end
            end
            S_MUL0: begin op_d = OP_MUL; src1_d = R1;  src2_d = R5; dest_d = R10; end
            S_MUL1: begin op_d = OP_MUL; src1_d = R2;  src2_d = R6; dest_d = R9;  end
            S_MUL2: begin op_d = OP_MUL; src1_d = R3;  src2_d = R7; dest_d = R9;  end
            S_MUL3: begin op_d = OP_MUL; src1_d = R4;  src2_d = R8; dest_d = R9;  end
            S_ADD1, S_ADD2, S_ADD3: begin
                op_d = OP_ADD; src1_d = R10; src2_d = R9; dest_d = R10;
            end
            S_OUT:   begin op_d = OP_COPY; src1_d = R10; dest_d = R0; end
            S_EIDLE: begin modwait_d = 1'b0; err_d = 1'b1; end
            default: modwait_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= S_IDLE;
            k       <= 2'd0;
            op      <= OP_NOP;
            src1    <= R0;
            src2    <= R0;
            dest    <= R0;
            modwait <= 1'b0;
            cnt_up  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            k       <= k_d;
            op      <= op_d;
            src1    <= src1_d;
            src2    <= src2_d;
            dest    <= dest_d;
            modwait <= modwait_d;
            cnt_up  <= cnt_up_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with a 16-bit register-file datapath model
// (saturating multiply, wrapping add with overflow flag).
module tb_fir_sequencer;
    import fir_pkg::*;

    logic       clk, n_reset, dr, lc, overflow;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;
    logic       modwait, cnt_up, err;

    logic signed [15:0] ext_data1, ext_data2;
    logic signed [15:0] rf [0:15];
    logic signed [16:0] alu_sum;
    logic signed [31:0] prod;

    int vectors     = 0;
    int miscompares = 0;

    fir_sequencer dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .dr       (dr),
        .lc       (lc),
        .overflow (overflow),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .modwait  (modwait),
        .cnt_up   (cnt_up),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)       return 16'sh7FFF;
        else if (v < -32'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    always_comb begin
        prod     = 32'(rf[src1]) * 32'(rf[src2]);
        alu_sum  = 17'sd0;
        overflow = 1'b0;
        if (op == OP_ADD)      alu_sum = 17'(rf[src1]) + 17'(rf[src2]);
        else if (op == OP_SUB) alu_sum = 17'(rf[src1]) - 17'(rf[src2]);
        if (op == OP_ADD || op == OP_SUB) overflow = alu_sum[16] ^ alu_sum[15];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'sd0;
        end else begin
            case (op)
                OP_COPY:        rf[dest] <= rf[src1];
                OP_LOAD1:       rf[dest] <= ext_data1;
                OP_LOAD2:       rf[dest] <= ext_data2;
                OP_ADD, OP_SUB: rf[dest] <= alu_sum[15:0];
                OP_MUL:         rf[dest] <= sat16(prod);
                default: ;
            endcase
        end
    end

    function automatic logic [17:0] pk(input logic [2:0] o, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] d,
                                       input logic mw, input logic cu, input logic er);
        return {o, a, b, d, mw, cu, er};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [17:0] exp);
        chk(tag, 32'(pk(op, src1, src2, dest, modwait, cnt_up, err)), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sample attempt: dr raised with v, dropped after step drop_at, 16 cycles observed
    task automatic run_sample(input logic signed [15:0] v, input int drop_at,
                              output int mw, output int cu, output bit saw_out);
        mw = 0; cu = 0; saw_out = 1'b0;
        dr = 1'b1;
        ext_data1 = v;
        for (int i = 0; i < 16; i++) begin
            step();
            if (modwait) mw++;
            if (cnt_up) cu++;
            if (op == OP_COPY && dest == R0) saw_out = 1'b1;
            if (i == 0) chk_outs("sh3", pk(OP_COPY, R3, R0, R4, 1, 0, 0));
            if (i == 3) begin
                if (drop_at >= 3) chk_outs("store", pk(OP_LOAD1, R0, R0, R1, 1, 1, 0));
                else              chk_outs("store_nop", pk(OP_NOP, R0, R0, R0, 1, 0, 0));
            end
            if (i == drop_at) dr = 1'b0;
        end
    endtask

    task automatic load_coef(input logic signed [15:0] v, input logic [1:0] kk);
        lc = 1'b1;
        ext_data2 = v;
        step();
        chk_outs("ldcoef", pk(OP_LOAD2, R0, R0, 4'(R5 + kk), 1, 0, 0));
        lc = 1'b0;
        step();
        chk_outs("waitc", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
    endtask

    initial begin
        int  mw, cu;
        bit  so;
        int  exp_r0 [4] = '{1, 4, 10, 20};

        n_reset = 1'b0; dr = 1'b0; lc = 1'b0; ext_data1 = '0; ext_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset_outs", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
        n_reset = 1'b1;
        step();
        chk_outs("idle_after_reset", pk(OP_NOP, R0, R0, R0, 0, 0, 0));

        // Coefficient load 1..4, then IDLE
        for (int j = 0; j < 4; j++) load_coef(16'(j + 1), 2'(j));
        step();
        chk_outs("idle_after_load", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
        chk("coefs", {rf[5][7:0], rf[6][7:0], rf[7][7:0], rf[8][7:0]}, 32'h01020304);

        // Samples 1..4
        for (int j = 0; j < 4; j++) begin
            run_sample(16'(j + 1), 4, mw, cu, so);
            chk("sample_modwait", 32'(mw), 32'd12);
            chk("sample_cnt_up", 32'(cu), 32'd1);
            chk("sample_out", 32'(so), 32'd1);
            chk("sample_r0", 32'(rf[0]), 32'(exp_r0[j]));
        end

        // dr dropped before STORE -> error, then recovery
        run_sample(16'sd9, 0, mw, cu, so);
        chk("drop_modwait", 32'(mw), 32'd4);
        chk("drop_cnt_up", 32'(cu), 32'd0);
        chk("drop_no_out", 32'(so), 32'd0);
        chk_outs("drop_eidle", pk(OP_NOP, R0, R0, R0, 0, 0, 1));
        chk("drop_r1", 32'(rf[1]), 32'd4);
        run_sample(16'sd5, 4, mw, cu, so);
        chk("recover_modwait", 32'(mw), 32'd12);
        chk("recover_cnt_up", 32'(cu), 32'd1);
        chk("recover_err", 32'(err), 32'd0);
        chk("recover_r0", 32'(rf[0]), 32'd37);

        // lc and dr together from IDLE; load 0x7FFF coefficients
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        step();
        lc = 1'b1; dr = 1'b1; ext_data2 = 16'sh7FFF; ext_data1 = 16'sh7FFF;
        step();
        chk_outs("lcdr_ldcoef", pk(OP_LOAD2, R0, R0, R5, 1, 0, 0));
        lc = 1'b0;
        step();
        chk_outs("lcdr_waitc", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
        step();
        chk_outs("lcdr_waitc_dr_ignored", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
        for (int j = 1; j < 4; j++) load_coef(16'sh7FFF, 2'(j));
        step();
        chk_outs("lcdr_idle", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
        run_sample(16'sh7FFF, 4, mw, cu, so);
        chk("big1_modwait", 32'(mw), 32'd12);
        chk("big1_r0", 32'(rf[0]), 32'h7FFF);

        // Second 0x7FFF sample overflows in ADD1
        run_sample(16'sh7FFF, 4, mw, cu, so);
        chk("ovf_modwait", 32'(mw), 32'd7);
        chk("ovf_cnt_up", 32'(cu), 32'd1);
        chk("ovf_no_out", 32'(so), 32'd0);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_r0", 32'(rf[0]), 32'h7FFF);
        chk("ovf_r10_written", 32'(rf[10][15:0]), 32'hFFFE);

        // Asynchronous reset during MUL2
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        dr = 1'b1; ext_data1 = 16'sd3;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) dr = 1'b0;
        end
        chk_outs("mul2", pk(OP_MUL, R3, R7, R9, 1, 0, 0));
        #2 n_reset = 1'b0;
        #1;
        chk_outs("async_reset", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
        @(posedge clk);
        #1 n_reset = 1'b1;
        step();
        chk_outs("idle_after_release", pk(OP_NOP, R0, R0, R0, 0, 0, 0));
        dr = 1'b1; ext_data1 = 16'sd1;
        step();
        chk_outs("restart_sh3", pk(OP_COPY, R3, R0, R4, 1, 0, 0));
        dr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
